// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing derivations and decoder state encodings, usable by receiver and transmitter.
package ws2812_pkg;

  localparam int CLK_FRE_DFLT      = 27_000_000;
  localparam int WS2812_WIDTH_DFLT = 24;
  localparam int CNT_W             = 16;
  localparam int PIX_W             = 9;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2
  } ws2812_state_e;

  function automatic int cyc_per_us(input int clk_fre);
    return clk_fre / 1_000_000;
  endfunction

  // 0.625 us: midpoint between the nominal 0-code and 1-code high times.
  function automatic int bit_threshold(input int clk_fre);
    return (cyc_per_us(clk_fre) * 5) / 8;
  endfunction

  function automatic int max_high(input int clk_fre);
    return cyc_per_us(clk_fre) * 2;
  endfunction

  function automatic int reset_gap(input int clk_fre);
    return cyc_per_us(clk_fre) * 50;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the WS2812 line; optional spike filter under WS2812_RX_GLITCH_FILTER_EN.
module ws2812_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic line
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

`ifdef WS2812_RX_GLITCH_FILTER_EN
  logic h1_q, line_q, line_d;

  // The line only follows a value the synchronizer has held on consecutive samples.
  always_comb begin
    line_d = line_q;
    if (s2_q == h1_q) line_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h1_q   <= 1'b0;
      line_q <= 1'b0;
    end else begin
      h1_q   <= s2_q;
      line_q <= line_d;
    end
  end

  assign line = line_q;
`else
  assign line = s2_q;
`endif

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: pulse-width bit decode, word assembly, frame/reset-gap detection.
// Build option WS2812_RX_GLITCH_FILTER_EN adds a spike filter in ws2812_rx_sync (+2 cycles latency).
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int CLK_FRE       = CLK_FRE_DFLT,
  parameter int WS2812_WIDTH  = WS2812_WIDTH_DFLT,
  parameter int BIT_THRESHOLD = bit_threshold(CLK_FRE),
  parameter int MAX_HIGH      = max_high(CLK_FRE),
  parameter int RESET_GAP     = reset_gap(CLK_FRE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din,
  output logic [WS2812_WIDTH-1:0] data,
  output logic                    data_valid,
  output logic                    frame_end,
  output logic [PIX_W-1:0]        pixel_count,
  output logic                    bit_error
);

  localparam int BIT_CW = $clog2(WS2812_WIDTH);

  logic line, line_q, rise, fall, bit_val;
  ws2812_state_e state_q, state_d;
  logic [CNT_W-1:0] low_q, low_d, high_q, high_d, low_inc, high_inc;
  logic [BIT_CW-1:0] bit_q, bit_d;
  logic [WS2812_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic dv_q, dv_d, fe_q, fe_d, be_q, be_d;

  ws2812_rx_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .line (line)
  );

  assign rise     = line & ~line_q;
  assign fall     = ~line & line_q;
  assign low_inc  = sat_inc(low_q);
  assign high_inc = sat_inc(high_q);
  assign bit_val  = (high_q > CNT_W'(BIT_THRESHOLD));

  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    high_d  = high_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    pix_d   = pix_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    be_d    = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (line) begin
          low_d = '0;
        end else begin
          low_d = low_inc;
          if (low_inc == CNT_W'(RESET_GAP)) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (rise) begin
          high_d  = CNT_W'(1);
          state_d = ST_HIGH;
        end else if (!line) begin
          low_d = low_inc;
          // Equality plus the previous-value guard makes this fire once per gap, even when saturated.
          if (low_inc == CNT_W'(RESET_GAP) && low_q != CNT_W'(RESET_GAP)) begin
            if (bit_q != '0) begin
              be_d    = 1'b1;
              fe_d    = 1'b1;
              bit_d   = '0;
              shift_d = '0;
              pix_d   = '0;
            end else if (pix_q != '0) begin
              fe_d  = 1'b1;
              pix_d = '0;
            end
          end
        end
      end
      ST_HIGH: begin
        if (fall) begin
          low_d          = CNT_W'(1);
          state_d        = ST_IDLE;
          shift_d[bit_q] = bit_val;
          if (bit_q == BIT_CW'(WS2812_WIDTH - 1)) begin
            data_d = shift_d;
            dv_d   = 1'b1;
            bit_d  = '0;
            pix_d  = (&pix_q) ? pix_q : pix_q + PIX_W'(1);
          end else begin
            bit_d = bit_q + BIT_CW'(1);
          end
        end else if (high_inc >= CNT_W'(MAX_HIGH)) begin
          be_d    = 1'b1;
          bit_d   = '0;
          shift_d = '0;
          low_d   = '0;
          state_d = ST_SYNC;
        end else begin
          high_d = high_inc;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q  <= 1'b0;
      state_q <= ST_SYNC;
      low_q   <= '0;
      high_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      pix_q   <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      be_q    <= 1'b0;
    end else begin
      line_q  <= line;
      state_q <= state_d;
      low_q   <= low_d;
      high_q  <= high_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      pix_q   <= pix_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      be_q    <= be_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = dv_q;
  assign frame_end   = fe_q;
  assign bit_error   = be_q;
  assign pixel_count = pix_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: decode, frame end, errors, timeout, thresholds, reset recovery.
module tb_ws2812_rx;

`ifdef WS2812_RX_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic [23:0] data;
  logic        data_valid, frame_end, bit_error;
  logic [8:0]  pixel_count;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_cnt = 0, fe_cnt = 0, be_cnt = 0;
  int b, fb, eb;
  logic [23:0] dv_log [0:63];

  ws2812_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .data       (data),
    .data_valid (data_valid),
    .frame_end  (frame_end),
    .pixel_count(pixel_count),
    .bit_error  (bit_error)
  );

  always #5 clk = ~clk;

  // Pulse monitor: outputs are registered on posedge, so each pulse is seen exactly once here.
  always @(negedge clk) begin
    if (data_valid) begin
      if (dv_cnt < 64) dv_log[dv_cnt] = data;
      dv_cnt++;
    end
    if (frame_end) fe_cnt++;
    if (bit_error) be_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic bv);
    if (bv) begin drive(1'b1, 23); drive(1'b0, 11); end
    else    begin drive(1'b1, 11); drive(1'b0, 23); end
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 0; i < 24; i++) send_bit(w[i]);
  endtask

  // Sends a word whose last bit is a 1, checking the data_valid latency from the falling edge.
  task automatic send_word_lat(input logic [23:0] w);
    for (int i = 0; i < 23; i++) send_bit(w[i]);
    drive(1'b1, 23);
    din = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      @(posedge clk); #1;
      chk("lat_early", 32'(data_valid), 32'd0);
    end
    @(posedge clk); #1;
    chk("lat_pulse", 32'(data_valid), 32'd1);
    chk("lat_data", 32'(data), 32'(w));
    @(posedge clk); #1;
    chk("dv_one_cycle", 32'(data_valid), 32'd0);
    @(negedge clk);
    drive(1'b0, 11 - (LAT + 2));
  endtask

  task automatic send_bit_spike(input logic bv);
    int l;
    l = bv ? 11 : 23;
    drive(1'b1, bv ? 23 : 11);
    drive(1'b0, 4);
    drive(1'b1, 1);
    drive(1'b0, l - 5);
  endtask

  initial begin
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_fe", 32'(frame_end), 32'd0);
    chk("rst_be", 32'(bit_error), 32'd0);
    chk("rst_pix", 32'(pixel_count), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1400);

    // Single word A5C3F0
    b = dv_cnt;
    send_word_lat(24'hA5C3F0);
    drive(1'b0, 20);
    chk("t1_dv_cnt", 32'(dv_cnt - b), 32'd1);
    chk("t1_log", 32'(dv_log[b]), 32'h00A5C3F0);
    chk("t1_pix", 32'(pixel_count), 32'd1);
    fb = fe_cnt;
    drive(1'b0, 1350);
    chk("t1_fe", 32'(fe_cnt - fb), 32'd1);
    chk("t1_pix_clr", 32'(pixel_count), 32'd0);
    chk("t1_data_hold", 32'(data), 32'h00A5C3F0);

    // Three-word frame
    b = dv_cnt; fb = fe_cnt; eb = be_cnt;
    send_word(24'h000001);
    send_word(24'hFFFFFF);
    send_word(24'h800000);
    chk("t2_pix3", 32'(pixel_count), 32'd3);
    drive(1'b0, 1350);
    chk("t2_dv_cnt", 32'(dv_cnt - b), 32'd3);
    chk("t2_w0", 32'(dv_log[b]), 32'h00000001);
    chk("t2_w1", 32'(dv_log[b + 1]), 32'h00FFFFFF);
    chk("t2_w2", 32'(dv_log[b + 2]), 32'h00800000);
    chk("t2_fe", 32'(fe_cnt - fb), 32'd1);
    chk("t2_be", 32'(be_cnt - eb), 32'd0);
    chk("t2_pix0", 32'(pixel_count), 32'd0);

    // Partial word followed by a gap
    b = dv_cnt; fb = fe_cnt; eb = be_cnt;
    for (int i = 0; i < 10; i++) send_bit(logic'(i % 3 == 0));
    drive(1'b0, 1350);
    chk("t3_be", 32'(be_cnt - eb), 32'd1);
    chk("t3_fe", 32'(fe_cnt - fb), 32'd1);
    chk("t3_dv", 32'(dv_cnt - b), 32'd0);
    chk("t3_data", 32'(data), 32'h00800000);

    // High-phase timeout, then a word that must be ignored until a full gap
    eb = be_cnt;
    drive(1'b1, 60);
    drive(1'b0, 20);
    chk("t4_be", 32'(be_cnt - eb), 32'd1);
    b = dv_cnt; fb = fe_cnt;
    send_word(24'h123456);
    drive(1'b0, 1350);
    chk("t4_dv_ignored", 32'(dv_cnt - b), 32'd0);
    chk("t4_fe_none", 32'(fe_cnt - fb), 32'd0);
    chk("t4_be_once", 32'(be_cnt - eb), 32'd1);
    chk("t4_data", 32'(data), 32'h00800000);

    // Threshold boundary: 17 high -> 1, 16 high -> 0
    b = dv_cnt;
    drive(1'b1, 17); drive(1'b0, 17);
    drive(1'b1, 16); drive(1'b0, 18);
    drive(1'b1, 17); drive(1'b0, 17);
    for (int i = 0; i < 21; i++) send_bit(1'b0);
    drive(1'b0, 20);
    chk("t5_dv", 32'(dv_cnt - b), 32'd1);
    chk("t5_data", 32'(data), 32'h00000005);
    chk("t5_pix", 32'(pixel_count), 32'd1);

    // Reset mid-word
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_data", 32'(data), 32'd0);
    chk("t6_pix", 32'(pixel_count), 32'd0);
    chk("t6_dv", 32'(data_valid), 32'd0);
    b = dv_cnt;
    send_word(24'hFFFFFF);
    drive(1'b0, 20);
    chk("t6_ignored", 32'(dv_cnt - b), 32'd0);
    chk("t6_data_hold", 32'(data), 32'd0);
    drive(1'b0, 1350);
    send_word(24'h0F0F0F);
    drive(1'b0, 20);
    chk("t6_dv_after", 32'(dv_cnt - b), 32'd1);
    chk("t6_data_after", 32'(data), 32'h000F0F0F);
    chk("t6_pix_after", 32'(pixel_count), 32'd1);

`ifdef WS2812_RX_GLITCH_FILTER_EN
    drive(1'b0, 1350);
    b = dv_cnt;
    for (int i = 0; i < 24; i++) send_bit_spike(logic'(i < 8));
    drive(1'b0, 20);
    chk("t7_dv", 32'(dv_cnt - b), 32'd1);
    chk("t7_data", 32'(data), 32'h000000FF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
